// File: rtl/binary_to_grey_if.sv
// Signal bundle for the binary/Gray converter: request side (din/mode/in_valid)
// and registered result side (dout/out_valid/out_adj).
interface binary_to_grey_if #(
  parameter int WIDTH = 4
) ();
  // Valid-only handshake: there is no ready. Every cycle with in_valid high is
  // accepted, and exactly one out_valid cycle follows one clock later.
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             out_adj;

  modport master (
    output din, in_valid, mode,
    input  dout, out_valid, out_adj
  );

  modport slave (
    input  din, in_valid, mode,
    output dout, out_valid, out_adj
  );
endinterface

// File: rtl/binary_to_grey.sv
// Registered binary<->Gray converter with 1-cycle latency and a
// single-bit-change (Gray adjacency) flag against the previous valid result.
module binary_to_grey #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_to_grey_if.slave      bus
);

  logic [WIDTH-1:0] gray_val;
  logic [WIDTH-1:0] bin_val;
  logic [WIDTH-1:0] conv_val;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] diff_m1;
  logic             one_bit_diff;

  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             adj_q;
  logic             has_prev_q;

  always_comb begin
    gray_val = bus.din ^ (bus.din >> 1);
  end

  // Gray-to-binary is a prefix XOR running from the MSB down.
  always_comb begin
    bin_val            = '0;
    bin_val[WIDTH-1]   = bus.din[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_val[i] = bin_val[i+1] ^ bus.din[i];
    end
  end

  always_comb begin
    conv_val = bus.mode ? bin_val : gray_val;
  end

  // dout only ever changes on a valid edge, so it doubles as the history
  // register; has_prev distinguishes "no result yet" from a genuine zero.
  always_comb begin
    diff         = conv_val ^ dout_q;
    diff_m1      = diff - WIDTH'(1);
    one_bit_diff = (diff != '0) && ((diff & diff_m1) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      valid_q    <= 1'b0;
      adj_q      <= 1'b0;
      has_prev_q <= 1'b0;
    end else if (bus.in_valid) begin
      dout_q     <= conv_val;
      valid_q    <= 1'b1;
      adj_q      <= has_prev_q && one_bit_diff;
      has_prev_q <= 1'b1;
    end else begin
      valid_q    <= 1'b0;
      adj_q      <= 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.out_adj   = adj_q;

endmodule

// File: tb/tb_binary_to_grey.sv
// Scoreboard bench for binary_to_grey: directed sequences, exhaustive and
// round-trip sweeps, random traffic with gaps, and mid-stream resets.
module tb_binary_to_grey;
  localparam int W = 4;

  logic clk;
  logic rst_n;

  binary_to_grey_if #(.WIDTH(W)) bus ();

  binary_to_grey #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: each entry is {adj, dout}
  logic [W:0]   exp_q[$];
  logic [W-1:0] held_dout = '0;
  logic [W-1:0] ref_prev  = '0;
  logic         ref_has_prev = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic ref_adj(input logic [W-1:0] v);
    return ref_has_prev && ($countones(v ^ ref_prev) == 1);
  endfunction

  // driver tasks: called just after a negedge, return at the next negedge
  task automatic send_exp(input logic [W-1:0] d, input logic m,
                          input logic [W-1:0] ed, input logic ea);
    bus.din      = d;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    exp_q.push_back({ea, ed});
    ref_prev     = ed;
    ref_has_prev = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    r = m ? from_gray(d) : to_gray(d);
    send_exp(d, m, r, ref_adj(r));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      bus.mode     = 1'($urandom_range(0, 1));
      bus.din      = W'($urandom_range(0, (1 << W) - 1));
      @(negedge clk);
    end
  endtask

  // async reset mid-cycle with a transfer in flight; it must be discarded
  task automatic mid_reset();
    bus.din      = W'($urandom_range(0, (1 << W) - 1));
    bus.mode     = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("reset_dout", int'(bus.dout), 0);
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_adj", int'(bus.out_adj), 0);
    exp_q.delete();
    held_dout    = '0;
    ref_prev     = '0;
    ref_has_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // monitor: every output cycle is either a due result or a hold cycle
  always @(posedge clk) begin
    logic [W:0] e;
    #1;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dout=%0d with nothing expected at %0t",
                 bus.dout, $time);
      end else begin
        e = exp_q.pop_front();
        check("dout", int'(bus.dout), int'(e[W-1:0]));
        check("out_adj", int'(bus.out_adj), int'(e[W]));
        held_dout = e[W-1:0];
      end
    end else begin
      check("missed_valid_pending", exp_q.size(), 0);
      check("hold_dout", int'(bus.dout), int'(held_dout));
      check("idle_adj", int'(bus.out_adj), 0);
    end
  end

  initial begin
    logic [W-1:0] g;
    rst_n        = 1'b0;
    bus.din      = '0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    check("init_dout", int'(bus.dout), 0);
    check("init_valid", int'(bus.out_valid), 0);
    check("init_adj", int'(bus.out_adj), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // bin-to-Gray directed: 0, 15, 8
    send_exp(4'd0, 1'b0, 4'd0, 1'b0);
    send_exp(4'd15, 1'b0, 4'd8, 1'b1);
    send_exp(4'd8, 1'b0, 4'd12, 1'b1);
    idle(2);

    // exhaustive bin-to-Gray after a fresh reset
    mid_reset();
    for (int v = 0; v < 16; v++) send(W'(v), 1'b0);
    idle(1);

    // Gray-to-binary directed
    mid_reset();
    send_exp(4'd8, 1'b1, 4'd15, 1'b0);
    send_exp(4'd12, 1'b1, 4'd8, 1'b0);
    send_exp(4'd0, 1'b1, 4'd0, 1'b1);
    send_exp(4'd4, 1'b1, 4'd7, 1'b0);
    idle(1);

    // round trip of every value
    for (int v = 0; v < 16; v++) begin
      g = to_gray(W'(v));
      send(W'(v), 1'b0);
      send_exp(g, 1'b1, W'(v), ref_adj(W'(v)));
    end
    idle(1);

    // non-adjacent, repeat, then valid gating
    mid_reset();
    send_exp(4'd0, 1'b0, 4'd0, 1'b0);
    send_exp(4'd5, 1'b0, 4'd7, 1'b0);
    send_exp(4'd5, 1'b0, 4'd7, 1'b0);
    send_exp(4'd7, 1'b0, 4'd4, 1'b0);
    idle(3);
    send_exp(4'd8, 1'b0, 4'd12, 1'b1);
    idle(1);

    // random traffic with random gaps and modes
    for (int n = 0; n < 200; n++) begin
      send(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (n == 120) mid_reset();
    end
    idle(3);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
